// File: rtl/reservation_station.sv
// reservation_station: 2-wide insert, completion-snooping storage, oldest-ready issue per FU port.
package rs_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic ALUSrc;
        logic MemRead;
        logic MemWrite;
        logic RegWrite;
    } control_t;
    typedef struct packed {
        control_t    control;
        logic [3:0]  alu_op;
        logic [15:0] imm;
    } instruction_t;
    typedef struct packed {
        logic              valid;
        instruction_t      instruction;
        logic [1:0]        fu;
        logic [3:0]        robNum;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rs1;
        logic [TAG_W-1:0]  rs2;
        logic              src1rdy;
        logic              src2rdy;
        logic [DATA_W-1:0] src1val;
        logic [DATA_W-1:0] src2val;
    } rsEntry;
endpackage

module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int N_FU  = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  rsEntry                        ins_a,
    input  rsEntry                        ins_b,
    input  logic [3:0]                    rob_head,
    input  logic                          flush,
    input  logic [N_FU-1:0]               cdb_valid,
    input  logic [N_FU-1:0][TAG_W-1:0]    cdb_tag,
    input  logic [N_FU-1:0][DATA_W-1:0]   cdb_data,
    input  logic [N_FU-1:0]               fu_ready,
    output rsEntry [N_FU-1:0]             issue,
    output logic                          rs_full,
    output logic [$clog2(DEPTH):0]        free_count,
    output logic                          overflow
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    rsEntry [DEPTH-1:0]        ent_q, ent_d;
    rsEntry [N_FU-1:0]         iss_q, iss_d;
    logic [CW-1:0]             free_q, free_d;
    logic                      full_q, full_d, ovf_q, ovf_d;
    logic [N_FU-1:0]           sel_v;
    logic [N_FU-1:0][IW-1:0]   sel_i;
    logic [3:0]                best, age;
    logic [DEPTH-1:0]          occ;
    logic                      done;
    rsEntry                    ln;

    // Descending scan with the original ready flags means the lowest matching port wins.
    function automatic rsEntry wake(rsEntry e, logic [N_FU-1:0] cv,
                                    logic [N_FU-1:0][TAG_W-1:0] ct,
                                    logic [N_FU-1:0][DATA_W-1:0] cd);
        logic r1, r2;
        r1 = e.src1rdy;
        r2 = e.src2rdy;
        for (int i = N_FU - 1; i >= 0; i--) begin
            if (cv[i] && !r1 && e.rs1 != '0 && e.rs1 == ct[i]) begin
                e.src1rdy = 1'b1;
                e.src1val = cd[i];
            end
            if (cv[i] && !r2 && e.rs2 != '0 && e.rs2 == ct[i]) begin
                e.src2rdy = 1'b1;
                e.src2val = cd[i];
            end
        end
        return e;
    endfunction

    always_comb begin
        ovf_d = ovf_q;
        best  = '0;
        age   = '0;
        done  = 1'b0;
        ln    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i].valid ? wake(ent_q[i], cdb_valid, cdb_tag, cdb_data) : ent_q[i];
            occ[i]   = ent_q[i].valid;
        end
        // Age is distance from the ROB head modulo 16, so the oldest entry has the smallest age.
        for (int k = 0; k < N_FU; k++) begin
            sel_v[k] = 1'b0;
            sel_i[k] = '0;
            best     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age = ent_q[i].robNum - rob_head;
                if (ent_q[i].valid && ent_q[i].src1rdy && ent_q[i].src2rdy && ent_q[i].fu == 2'(k)
                    && (!sel_v[k] || age < best)) begin
                    sel_v[k] = 1'b1;
                    sel_i[k] = IW'(i);
                    best     = age;
                end
            end
            iss_d[k] = !fu_ready[k] ? iss_q[k] : sel_v[k] ? ent_q[sel_i[k]] : '0;
            if (fu_ready[k] && sel_v[k]) ent_d[sel_i[k]].valid = 1'b0;
        end
        // Allocation uses pre-edge occupancy, so slots freed this edge stay unusable until next cycle.
        for (int l = 0; l < 2; l++) begin
            ln = (l == 0) ? ins_a : ins_b;
            if (ln.valid) begin
                ln.src2rdy = ln.src2rdy | ln.instruction.control.ALUSrc;
                ln   = wake(ln, cdb_valid, cdb_tag, cdb_data);
                done = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!done && !occ[i]) begin
                        ent_d[i] = ln;
                        occ[i]   = 1'b1;
                        done     = 1'b1;
                    end
                end
                if (!done) ovf_d = 1'b1;
            end
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            iss_d = '0;
            ovf_d = ovf_q;
        end
        free_d = CW'(DEPTH);
        for (int i = 0; i < DEPTH; i++) free_d = free_d - CW'(ent_d[i].valid);
        full_d = free_d < CW'(2);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ent_q  <= '0;
            iss_q  <= '0;
            free_q <= CW'(DEPTH);
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            iss_q  <= iss_d;
            free_q <= free_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign issue      = iss_q;
    assign free_count = free_q;
    assign rs_full    = full_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed steps with hand-computed expectations checked by immediate assertions.
module tb_reservation_station;
    import rs_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    rsEntry                ins_a, ins_b;
    logic [3:0]            rob_head;
    logic                  flush;
    logic [2:0]            cdb_valid;
    logic [2:0][5:0]       cdb_tag;
    logic [2:0][31:0]      cdb_data;
    logic [2:0]            fu_ready;
    rsEntry [2:0]          issue;
    logic                  rs_full;
    logic [4:0]            free_count;
    logic                  overflow;
    int                    total = 0;
    int                    bad = 0;

    reservation_station #(.DEPTH(16), .N_FU(3)) dut (
        .clk(clk), .reset_n(reset_n), .ins_a(ins_a), .ins_b(ins_b), .rob_head(rob_head),
        .flush(flush), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_ready(fu_ready), .issue(issue), .rs_full(rs_full), .free_count(free_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic rsEntry mk(logic [1:0] fu, logic [3:0] rob, logic [5:0] t1, logic [5:0] t2,
                                  logic r1, logic r2, logic [31:0] v1, logic [31:0] v2, logic als);
        rsEntry e;
        e = '0;
        e.valid = 1'b1;
        e.fu = fu;
        e.robNum = rob;
        e.rs1 = t1;
        e.rs2 = t2;
        e.src1rdy = r1;
        e.src2rdy = r2;
        e.src1val = v1;
        e.src2val = v2;
        e.instruction.control.ALUSrc = als;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ins_a = '0;
        ins_b = '0;
        cdb_valid = '0;
        flush = 1'b0;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        cdb_tag = '0;
        cdb_data = '0;
        rob_head = 4'd0;
        fu_ready = 3'b111;
        reset_n = 1'b0;
        ins_a = mk(2'd0, 4'd0, 6'd1, 6'd2, 1, 1, 32'd1, 32'd2, 0);
        tick();
        chk("rst_free", 64'(free_count), 64'd16);
        chk("rst_full", 64'(rs_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_iss_v", 64'({issue[2].valid, issue[1].valid, issue[0].valid}), 64'd0);
        reset_n = 1'b1;
        idle();
        tick();
        chk("rst_free2", 64'(free_count), 64'd16);

        ins_a = mk(2'd0, 4'd0, 6'd3, 6'd4, 1, 1, 32'd5, 32'd0, 0);
        tick();
        idle();
        chk("t1_free15", 64'(free_count), 64'd15);
        chk("t1_not_yet", 64'(issue[0].valid), 64'd0);
        tick();
        chk("t1_iss_v", 64'(issue[0].valid), 64'd1);
        chk("t1_src1", 64'(issue[0].src1val), 64'd5);
        chk("t1_free16", 64'(free_count), 64'd16);

        ins_a = mk(2'd0, 4'd1, 6'd12, 6'd0, 0, 1, 32'd0, 32'd0, 0);
        tick();
        idle();
        chk("t2_empty", 64'(issue[0].valid), 64'd0);
        cdb_valid = 3'b110;
        cdb_tag[1] = 6'd12;
        cdb_data[1] = 32'hDEAD;
        cdb_tag[2] = 6'd12;
        cdb_data[2] = 32'h999;
        tick();
        idle();
        chk("t2_wait", 64'(issue[0].valid), 64'd0);
        tick();
        chk("t2_iss_v", 64'(issue[0].valid), 64'd1);
        chk("t2_wake", 64'(issue[0].src1val), 64'hDEAD);

        ins_a = mk(2'd0, 4'd2, 6'd0, 6'd7, 1, 0, 32'd1, 32'd0, 0);
        cdb_valid = 3'b001;
        cdb_tag[0] = 6'd7;
        cdb_data[0] = 32'h42;
        tick();
        idle();
        tick();
        chk("t3_iss_v", 64'(issue[0].valid), 64'd1);
        chk("t3_bypass", 64'(issue[0].src2val), 64'h42);

        rob_head = 4'd14;
        ins_a = mk(2'd1, 4'd1, 6'd0, 6'd0, 1, 1, 32'd11, 32'd0, 0);
        ins_b = mk(2'd1, 4'd15, 6'd0, 6'd0, 1, 1, 32'd22, 32'd0, 0);
        tick();
        idle();
        tick();
        chk("t4_first_v", 64'(issue[1].valid), 64'd1);
        chk("t4_first", 64'(issue[1].robNum), 64'd15);
        tick();
        chk("t4_second", 64'(issue[1].robNum), 64'd1);
        chk("t4_second_v", 64'(issue[1].valid), 64'd1);
        tick();
        chk("t4_drain", 64'(issue[1].valid), 64'd0);
        rob_head = 4'd0;

        fu_ready = 3'b011;
        ins_a = mk(2'd2, 4'd3, 6'd0, 6'd0, 1, 1, 32'h77, 32'd0, 0);
        tick();
        idle();
        tick();
        chk("t6_hold_v", 64'(issue[2].valid), 64'd0);
        chk("t6_retain", 64'(free_count), 64'd15);
        fu_ready = 3'b111;
        tick();
        chk("t6_iss_v", 64'(issue[2].valid), 64'd1);
        chk("t6_src1", 64'(issue[2].src1val), 64'h77);
        chk("t6_free", 64'(free_count), 64'd16);
        fu_ready = 3'b011;
        tick();
        chk("t6_keep", 64'(issue[2].valid), 64'd1);
        fu_ready = 3'b111;
        ins_a = mk(2'd0, 4'd4, 6'd30, 6'd0, 0, 1, 32'd0, 32'd0, 0);
        tick();
        chk("t6_pre_flush", 64'(free_count), 64'd15);
        flush = 1'b1;
        ins_a = mk(2'd0, 4'd5, 6'd31, 6'd0, 0, 1, 32'd0, 32'd0, 0);
        tick();
        idle();
        chk("flush_free", 64'(free_count), 64'd16);
        chk("flush_iss", 64'({issue[2].valid, issue[1].valid, issue[0].valid}), 64'd0);
        chk("flush_no_ovf", 64'(overflow), 64'd0);

        ins_a = mk(2'd0, 4'd6, 6'd40, 6'd9, 1, 0, 32'h5, 32'h0, 1);
        tick();
        idle();
        tick();
        chk("alusrc_v", 64'(issue[0].valid), 64'd1);
        chk("alusrc_rdy", 64'(issue[0].src2rdy), 64'd1);

        for (int n = 0; n < 7; n++) begin
            ins_a = mk(2'd0, 4'(2 * n), 6'd20, 6'd0, 0, 1, 32'd0, 32'd0, 0);
            ins_b = mk(2'd0, 4'(2 * n + 1), 6'd20, 6'd0, 0, 1, 32'd0, 32'd0, 0);
            tick();
        end
        chk("fill_free2", 64'(free_count), 64'd2);
        chk("fill_not_full", 64'(rs_full), 64'd0);
        ins_a = mk(2'd0, 4'd14, 6'd20, 6'd0, 0, 1, 32'd0, 32'd0, 0);
        ins_b = '0;
        tick();
        chk("fill_full15", 64'(rs_full), 64'd1);
        chk("fill_free1", 64'(free_count), 64'd1);
        tick();
        chk("fill_free0", 64'(free_count), 64'd0);
        chk("fill_no_ovf", 64'(overflow), 64'd0);
        tick();
        idle();
        chk("ovf_set", 64'(overflow), 64'd1);
        tick();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("fill_noissue", 64'(issue[0].valid), 64'd0);
        flush = 1'b1;
        tick();
        idle();
        chk("fill_flush", 64'(free_count), 64'd16);
        chk("ovf_after_flush", 64'(overflow), 64'd1);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("ovf_clear", 64'(overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
